pic_ram_arbiter: RTL
====================

Name: pic_ram_arbiter

Overview:
- Shares one single-port picture RAM (RGB565, one word per pixel) between two requesters:
  - the VGA display read path, driven by addr_h/addr_v from vga_display_pic;
  - a picture loader write port with a valid/ready handshake.
- Display reads have absolute priority. Loader writes fill the remaining cycles.
- Produces the rgb_data word consumed by vga_display_pic. Replaces data_drive when the picture comes from RAM instead of ROM.

Parameters:
- PIC_X, 12'd0, left column of picture window (screen pixels)
- PIC_Y, 12'd0, top row of picture window
- PIC_W, 12'd100, picture width in pixels
- PIC_H, 12'd100, picture height in pixels
- ADDR_W, 14, RAM address width; must satisfy 2^ADDR_W >= PIC_W*PIC_H
- BG_COLOR, 16'h0000, RGB565 value output outside the window

Ports:
- vga_clk  in  1  pixel clock; sole clock
- rst  in  1  synchronous, active-high reset
- disp_en  in  1  addr_h/addr_v is an active-area pixel this cycle
- addr_h  in  12  current column
- addr_v  in  12  current row
- rgb_data  out  16  pixel colour, 3 cycles after its address
- wr_valid  in  1  loader has a write
- wr_ready  out  1  write accepted this cycle (combinational)
- wr_addr  in  ADDR_W  linear pixel index
- wr_data  in  16  RGB565 write data
- ram_addr  out  ADDR_W  registered RAM address
- ram_we  out  1  registered RAM write enable
- ram_wdata  out  16  registered RAM write data
- ram_rdata  in  16  RAM read data, valid 1 cycle after ram_addr (synchronous RAM)
- load_cnt  out  ADDR_W+1  count of accepted in-range writes
- load_done  out  1  sticky; set when load_cnt reaches PIC_W*PIC_H
- wr_err  out  1  sticky; an accepted write had wr_addr >= PIC_W*PIC_H

Behaviour:
- **Hit definition:** hit = disp_en & PIC_X<=addr_h<PIC_X+PIC_W & PIC_Y<=addr_v<PIC_Y+PIC_H. Use unsigned compares at 12 bits, with the window end computed at 13 bits so there is no wrap.
- **Read address:** rd_addr = (addr_v-PIC_Y)*PIC_W + (addr_h-PIC_X), truncated to ADDR_W.
- **Cycle t arbitration (edge at end of t):**
  - If hit: ram_addr<=rd_addr, ram_we<=0.
  - Else if wr_valid & wr_ready: ram_addr<=wr_addr, ram_wdata<=wr_data, ram_we<=1.
  - Else: ram_we<=0 and ram_addr holds.
- **wr_ready** = !hit & !rst & wr_allow.
  - wr_allow=1 in the base build; see the Optional Feature for the other case.
  - A write is never stalled by its own data. The loader must hold wr_valid, wr_addr and wr_data until it sees wr_ready.
- **Read pipeline:**
  - hit_d1 and hit_d2 track the request through the pipeline.
  - At t+2, rgb_data <= hit_d2 ? ram_rdata : BG_COLOR.
  - Total latency is addr to rgb_data = 3 cycles, fixed, independent of write traffic.
- **Out-of-range writes (wr_addr >= PIC_W*PIC_H):**
  - The handshake still completes, but ram_we stays 0 (the write is dropped).
  - wr_err is set; load_cnt does not increment.
- **In-range accepted writes:** load_cnt increments and saturates at PIC_W*PIC_H. load_done is set when load_cnt becomes PIC_W*PIC_H.
  - Writes to an already-written address still count. load_done signals a write count, not coverage.
- **Reset (synchronous, any time, including mid-write):**
  - Outputs: rgb_data=BG_COLOR, ram_we=0, ram_addr=0, ram_wdata=0, load_cnt=0, load_done=0, wr_err=0.
  - Internal state: hit_d1, hit_d2 and the tear-free FSM are cleared.
  - A write presented during reset is not accepted.
- **Simultaneous hit and wr_valid:** the read wins; wr_ready=0 that cycle.

Optional Feature:
- Macro: PIC_TEARFREE_EN.
- **Defined:** a 2-state FSM gates writes.
  - SCAN: addr_v is within [PIC_Y, PIC_Y+PIC_H). wr_allow=0.
  - BLANK: any other row. wr_allow=1.
  - State updates each cycle from addr_v, registered, so wr_allow lags the row change by 1 cycle.
  - The first cycle after reset is SCAN.
  - Result: loader writes never coincide with picture rows, so no tearing.
- **Undefined:** wr_allow is tied to 1. Writes interleave with the scan in any non-hit cycle, including horizontal gaps inside picture rows.

Test Plan:
1. **Priority collision:**
   - Stimulus: PIC_X=10, PIC_Y=5, PIC_W=PIC_H=100, disp_en=1, addr_h=10, addr_v=5, wr_valid=1.
   - Response: wr_ready=0, ram_addr=0 next cycle, ram_we=0.
2. **Idle write:**
   - Stimulus: disp_en=0, wr_valid=1, wr_addr=42, wr_data=16'hF800.
   - Response: wr_ready=1; next cycle ram_we=1, ram_addr=42, ram_wdata=16'hF800; load_cnt=1.
3. **Read latency:**
   - Stimulus: RAM preloaded with word[205]=16'h07E0; addr_h=15, addr_v=7, hit.
   - Response: rgb_data=16'h07E0 exactly 3 cycles later. Pixel (9,7) gives BG_COLOR after 3 cycles.
4. **Out-of-range write:**
   - Stimulus: wr_addr=10000 with PIC_W*PIC_H=10000.
   - Response: wr_ready=1, ram_we stays 0, wr_err=1, load_cnt unchanged.
5. **Full load:**
   - Stimulus: 10000 in-range writes during disp_en=0.
   - Response: load_done rises on the cycle after the 10000th handshake; load_cnt saturates at 10000 after a further write.
6. **Reset and tear-free mode:**
   - Stimulus: assert rst mid-write; separately, with PIC_TEARFREE_EN defined, use addr_v=50 and disp_en=0.
   - Response: after rst, all outputs hold their reset values and no ram_we pulse occurs. In the tear-free case wr_ready=0; at addr_v=200 wr_ready=1 one cycle after the row change.

Source files
------------

// File: rtl/pic_ram_arbiter_if.sv
// Loader write port of the picture RAM arbiter: valid/ready handshake
// carrying a linear pixel index and one RGB565 word.
// The loader side uses the master modport, the arbiter the slave modport.
interface pic_ram_arbiter_if #(
  parameter int ADDR_W = 14
);
  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [15:0]       wr_data;

  modport master (output wr_valid, output wr_addr, output wr_data, input wr_ready);
  modport slave  (input wr_valid, input wr_addr, input wr_data, output wr_ready);
endinterface

// File: rtl/pic_ram_arbiter.sv
// Picture RAM arbiter: shares one single-port synchronous RAM (RGB565, one
// word per pixel) between the VGA display read path and a picture loader.
// Display reads always win; loader writes use the cycles left over.
// rgb_data follows its pixel address by a fixed 3 cycles.
// Optional macro PIC_TEARFREE_EN: when defined, loader writes are only
// allowed while the scan is on a row outside the picture window.
module pic_ram_arbiter #(
  parameter logic [11:0] PIC_X    = 12'd0,
  parameter logic [11:0] PIC_Y    = 12'd0,
  parameter logic [11:0] PIC_W    = 12'd100,
  parameter logic [11:0] PIC_H    = 12'd100,
  parameter int          ADDR_W   = 14,
  parameter logic [15:0] BG_COLOR = 16'h0000
) (
  input  logic              vga_clk,
  input  logic              rst,
  input  logic              disp_en,
  input  logic [11:0]       addr_h,
  input  logic [11:0]       addr_v,
  output logic [15:0]       rgb_data,
  pic_ram_arbiter_if.slave  wr,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [15:0]       ram_wdata,
  input  logic [15:0]       ram_rdata,
  output logic [ADDR_W:0]   load_cnt,
  output logic              load_done,
  output logic              wr_err
);

  // Window ends are one bit wider so a window touching 4095 cannot wrap.
  localparam logic [12:0]   X_END = {1'b0, PIC_X} + {1'b0, PIC_W};
  localparam logic [12:0]   Y_END = {1'b0, PIC_Y} + {1'b0, PIC_H};
  localparam logic [ADDR_W:0] AREA = (ADDR_W + 1)'(32'(PIC_W) * 32'(PIC_H));

  logic              in_cols;
  logic              in_rows;
  logic              hit;
  logic [11:0]       rel_h;
  logic [11:0]       rel_v;
  logic [ADDR_W-1:0] rd_addr;
  logic              wr_allow;
  logic              wr_fire;
  logic              wr_in_range;

  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic              ram_we_q, ram_we_d;
  logic [15:0]       ram_wdata_q, ram_wdata_d;
  logic [ADDR_W:0]   load_cnt_q, load_cnt_d;
  logic              load_done_q, load_done_d;
  logic              wr_err_q, wr_err_d;
  logic              hit_d1_q, hit_d2_q;
  logic [15:0]       rgb_q;

  assign in_cols = (addr_h >= PIC_X) && ({1'b0, addr_h} < X_END);
  assign in_rows = (addr_v >= PIC_Y) && ({1'b0, addr_v} < Y_END);
  assign hit     = disp_en && in_cols && in_rows;

  assign rel_h   = addr_h - PIC_X;
  assign rel_v   = addr_v - PIC_Y;
  assign rd_addr = ADDR_W'(({12'd0, rel_v} * {12'd0, PIC_W}) + {12'd0, rel_h});

  assign wr_in_range = ({1'b0, wr.wr_addr} < AREA);
  assign wr.wr_ready = !hit && !rst && wr_allow;
  assign wr_fire     = wr.wr_valid && wr.wr_ready;

`ifdef PIC_TEARFREE_EN
  typedef enum logic {SCAN, BLANK} tf_state_e;
  tf_state_e tf_state_q;

  // Track whether the previous cycle's row lay inside the picture window.
  always_ff @(posedge vga_clk) begin
    if (rst) begin
      tf_state_q <= SCAN;
    end else if (in_rows) begin
      tf_state_q <= SCAN;
    end else begin
      tf_state_q <= BLANK;
    end
  end

  assign wr_allow = (tf_state_q == BLANK);
`else
  assign wr_allow = 1'b1;
`endif

  // Choose this cycle's RAM access: display read first, then a loader write.
  always_comb begin
    ram_addr_d  = ram_addr_q;
    ram_we_d    = 1'b0;
    ram_wdata_d = ram_wdata_q;
    if (hit) begin
      ram_addr_d = rd_addr;
    end else if (wr_fire && wr_in_range) begin
      ram_addr_d  = wr.wr_addr;
      ram_wdata_d = wr.wr_data;
      ram_we_d    = 1'b1;
    end
  end

  // Count accepted in-range writes and flag writes that fall off the picture.
  always_comb begin
    load_cnt_d  = load_cnt_q;
    load_done_d = load_done_q;
    wr_err_d    = wr_err_q;
    if (wr_fire) begin
      if (wr_in_range) begin
        if (load_cnt_q < AREA) begin
          load_cnt_d = load_cnt_q + {{ADDR_W{1'b0}}, 1'b1};
        end
        if (load_cnt_d == AREA) begin
          load_done_d = 1'b1;
        end
      end else begin
        wr_err_d = 1'b1;
      end
    end
  end

  // Register the RAM command and the loader bookkeeping.
  always_ff @(posedge vga_clk) begin
    if (rst) begin
      ram_addr_q  <= '0;
      ram_we_q    <= 1'b0;
      ram_wdata_q <= '0;
      load_cnt_q  <= '0;
      load_done_q <= 1'b0;
      wr_err_q    <= 1'b0;
    end else begin
      ram_addr_q  <= ram_addr_d;
      ram_we_q    <= ram_we_d;
      ram_wdata_q <= ram_wdata_d;
      load_cnt_q  <= load_cnt_d;
      load_done_q <= load_done_d;
      wr_err_q    <= wr_err_d;
    end
  end

  // Carry the hit flag alongside the RAM read and pick pixel or background.
  always_ff @(posedge vga_clk) begin
    if (rst) begin
      hit_d1_q <= 1'b0;
      hit_d2_q <= 1'b0;
      rgb_q    <= BG_COLOR;
    end else begin
      hit_d1_q <= hit;
      hit_d2_q <= hit_d1_q;
      rgb_q    <= hit_d2_q ? ram_rdata : BG_COLOR;
    end
  end

  assign ram_addr  = ram_addr_q;
  assign ram_we    = ram_we_q;
  assign ram_wdata = ram_wdata_q;
  assign load_cnt  = load_cnt_q;
  assign load_done = load_done_q;
  assign wr_err    = wr_err_q;
  assign rgb_data  = rgb_q;

endmodule
